pio_pc_sequencer: RTL

Program-counter sequencer for one PIO state machine. It drives the read address of the 32x16 instruction register file and presents the fetched instruction to the execute stage. It also applies the wrap window, jumps, execute stalls and the per-instruction delay field. One instance exists per state machine, sitting between instruction_regfile's read port and the execute unit.

---
 rtl/pio_pkg.sv | 16 +
 rtl/pio_delay_counter.sv | 39 +++
 rtl/pio_pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared widths, delay-field position and state encoding for the PIO pc sequencer
package pio_pkg;

    localparam int ADDR_W    = 5;
    localparam int INSTR_W   = 16;
    localparam int DELAY_W   = 5;
    localparam int DELAY_LSB = 8;
    localparam int DELAY_MSB = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DELAY = 2'd2
    } state_e;

endpackage

// File: rtl/pio_delay_counter.sv
// rtl/pio_delay_counter.sv - per-instruction delay down-counter: load, decrement on enable, done at last cycle
module pio_delay_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // done marks the final delay cycle so the sequencer re-enters EXEC on the next edge
    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/pio_pc_sequencer.sv
// rtl/pio_pc_sequencer.sv - PIO program counter sequencer (optional forced-instruction port: PIO_FORCED_INSTR_EN)
module pio_pc_sequencer #(
    parameter int ADDR_W  = pio_pkg::ADDR_W,
    parameter int INSTR_W = pio_pkg::INSTR_W,
    parameter int DELAY_W = pio_pkg::DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    input  logic [ADDR_W-1:0]  wrap_bottom,
    input  logic [ADDR_W-1:0]  wrap_top,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_stall,
    input  logic               jmp_taken,
    input  logic [ADDR_W-1:0]  jmp_target,
`ifdef PIO_FORCED_INSTR_EN
    input  logic [INSTR_W-1:0] forced_instr,
    input  logic               forced_valid,
    output logic               forced_ready,
`endif
    output logic               in_delay,
    output logic [ADDR_W-1:0]  pc
);

    import pio_pkg::*;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                cnt_clear;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_done;
    logic [DELAY_W-1:0]  delay_field;
    logic [ADDR_W-1:0]   seq_pc;
    logic                forced_act;

    assign delay_field = imem_data[DELAY_LSB +: DELAY_W];
    assign seq_pc      = (pc_q == wrap_top) ? wrap_bottom : pc_q + ADDR_W'(1);

`ifdef PIO_FORCED_INSTR_EN
    // a forced instruction bypasses en but never interrupts a delay
    assign forced_act   = forced_valid && ((state_q == IDLE) || (state_q == EXEC));
    assign forced_ready = forced_act && !exec_stall;
    assign instr        = forced_act ? forced_instr : imem_data;
    assign instr_valid  = forced_act || (en && (state_q == EXEC));
`else
    assign forced_act   = 1'b0;
    assign instr        = imem_data;
    assign instr_valid  = en && (state_q == EXEC);
`endif

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign in_delay  = (state_q == DELAY);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (restart) begin
            pc_d      = wrap_bottom;
            cnt_clear = 1'b1;
            state_d   = en ? EXEC : IDLE;
        end else if (forced_act) begin
            if (!exec_stall && jmp_taken) begin
                pc_d = jmp_target;
            end
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    state_d = EXEC;
                end
                EXEC: begin
                    if (!exec_stall) begin
                        pc_d = jmp_taken ? jmp_target : seq_pc;
                        if (delay_field != '0) begin
                            state_d  = DELAY;
                            cnt_load = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    cnt_dec = 1'b1;
                    if (cnt_done) begin
                        state_d = EXEC;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    pio_delay_counter #(
        .W(DELAY_W)
    ) u_delay_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (delay_field),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

endmodule
